seven_seg_scan: RTL and testbench

//  Multiplexed N-digit seven-segment display driver, the successor to the single-digit decoder.

---
 rtl/seven_seg_pkg.sv | 18 +
 rtl/seven_seg_if.sv | 33 +++
 rtl/seven_seg_dec.sv | 11 +
 rtl/seven_seg_scan.sv | 120 ++++++++++++
 tb/tb_seven_seg_scan.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/seven_seg_pkg.sv
// Shared definitions for the multiplexed seven-segment display driver.
//   SEG_W : width of a segment pattern, {a,b,c,d,e,f,g} with a in bit 6
//   HEX7  : active-high segment pattern for every hex nibble
//   hex7(): nibble -> active-high segment pattern lookup
package seven_seg_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] HEX7 [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  function automatic logic [SEG_W-1:0] hex7(input logic [3:0] nibble);
    return HEX7[nibble];
  endfunction

endpackage

// File: rtl/seven_seg_if.sv
// Bus between the datapath (master) and the display driver (slave).
//   load       master->slave  1-cycle strobe capturing value/dp_in
//   value      master->slave  hex nibbles, digit 0 = value[3:0]
//   dp_in      master->slave  decimal-point request per digit
//   pend       slave->master  pending buffer not yet shown
//   load_ack   slave->master  1-cycle pulse when pending data is committed
//   frame_tick slave->master  1-cycle pulse when the scan returns to digit 0
//   seg/dp/an  slave->pins    segment lines, decimal point, digit enables
interface seven_seg_if
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    pend;
  logic                    load_ack;
  logic                    frame_tick;
  logic [SEG_W-1:0]        seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;

  modport master (
    output load, value, dp_in,
    input  pend, load_ack, frame_tick, seg, dp, an
  );

  modport slave (
    input  load, value, dp_in,
    output pend, load_ack, frame_tick, seg, dp, an
  );
endinterface

// File: rtl/seven_seg_dec.sv
// Combinational hex nibble to active-high seven-segment pattern decoder.
//   nibble : 4-bit hex digit
//   seg    : {a,b,c,d,e,f,g}, active-high
module seven_seg_dec
  import seven_seg_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg
);
  assign seg = hex7(nibble);
endmodule

// File: rtl/seven_seg_scan.sv
// Multiplexed N-digit seven-segment display driver with a tear-free,
// double-buffered display value. One digit is lit for PRESCALE clocks, then
// the scan moves on; new data is only committed when the scan wraps to digit 0.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : seven_seg_if slave modport (load/value/dp_in in; pend, load_ack,
//           frame_tick, seg, dp, an out)
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits
// (digit 0 is never blanked, the decimal point is still shown).
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 1000,
  parameter int ACTIVE_LOW = 0
) (
  input logic        clk,
  input logic        rst_n,
  seven_seg_if.slave bus
);
  localparam int   DATA_W  = 4 * NUM_DIGITS;
  localparam int   IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int   PRESC_W = $clog2(PRESCALE);
  localparam logic POL     = (ACTIVE_LOW != 0);

  logic [PRESC_W-1:0]    presc;
  logic [IDX_W-1:0]      idx;
  logic [DATA_W-1:0]     pending, disp;
  logic [NUM_DIGITS-1:0] pending_dp, disp_dp;
  logic                  pend_q, load_ack_q, frame_tick_q;
  logic [SEG_W-1:0]      seg_q;
  logic                  dp_q;
  logic [NUM_DIGITS-1:0] an_q;

  logic                  tick, last_digit, wrap;
  logic [3:0]            nibble;
  logic [SEG_W-1:0]      dec_seg, seg_hi;
  logic [NUM_DIGITS-1:0] an_hi, dp_sel;
  logic                  blank;

  assign tick       = (presc == PRESC_W'(PRESCALE - 1));
  assign last_digit = (idx == IDX_W'(NUM_DIGITS - 1));
  assign wrap       = tick && last_digit;

  assign nibble = disp[4 * int'(idx) +: 4];
  assign dp_sel = disp_dp >> idx;
  assign an_hi  = NUM_DIGITS'(1) << idx;

  seven_seg_dec u_dec (
    .nibble (nibble),
    .seg    (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blank when it and every digit to its left hold zero.
  assign blank = (idx != '0) && ((disp >> (4 * int'(idx))) == '0);
`else
  assign blank = 1'b0;
`endif

  // NOTE: combinational outputs get a default first so no path infers a latch.
  always_comb begin
    seg_hi = dec_seg;
    if (blank) seg_hi = '0;
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc        <= '0;
      idx          <= '0;
      pending      <= '0;
      pending_dp   <= '0;
      disp         <= '0;
      disp_dp      <= '0;
      pend_q       <= 1'b0;
      load_ack_q   <= 1'b0;
      frame_tick_q <= 1'b0;
      seg_q        <= {SEG_W{POL}};
      dp_q         <= POL;
      an_q         <= {NUM_DIGITS{POL}};
    end else begin
      presc <= tick ? '0 : presc + PRESC_W'(1);
      if (tick) idx <= last_digit ? '0 : idx + IDX_W'(1);

      frame_tick_q <= wrap;
      load_ack_q   <= wrap && (bus.load || pend_q);

      // Commit only on the wrap so a frame never mixes old and new digits.
      // A load on the wrap cycle itself bypasses the pending buffer.
      if (wrap && bus.load) begin
        disp    <= bus.value;
        disp_dp <= bus.dp_in;
        pend_q  <= 1'b0;
      end else if (wrap && pend_q) begin
        disp    <= pending;
        disp_dp <= pending_dp;
        pend_q  <= 1'b0;
      end else if (bus.load) begin
        pending    <= bus.value;
        pending_dp <= bus.dp_in;
        pend_q     <= 1'b1;
      end

      // Pin polarity is applied here so the logic above stays active-high.
      seg_q <= seg_hi ^ {SEG_W{POL}};
      dp_q  <= dp_sel[0] ^ POL;
      an_q  <= an_hi ^ {NUM_DIGITS{POL}};
    end
  end

  assign bus.pend       = pend_q;
  assign bus.load_ack   = load_ack_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan. A reference model derives every
// expected output from the clock count since reset (which digit is lit, when
// the frame wraps) and from the load history, and queues one expected record
// per clock; a monitor pops and compares each record half a clock later.
// Two instances: 4 digits active-high, and 1 digit active-low.
module tb_seven_seg_scan;

  localparam int PRESC = 4;

  localparam logic [6:0] SEG_REF [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       ft;
    logic       ack;
    logic       pend;
  } obs_t;

  typedef struct packed {
    logic [31:0] k;      // clock edges since reset released
    logic [15:0] disp;
    logic [3:0]  ddp;
    logic [15:0] pval;
    logic [3:0]  pdp;
    logic        pend;
  } mstate_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seven_seg_if #(.NUM_DIGITS(4)) bus4 ();
  seven_seg_if #(.NUM_DIGITS(1)) bus1 ();

  seven_seg_scan #(.NUM_DIGITS(4), .PRESCALE(PRESC), .ACTIVE_LOW(0)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  seven_seg_scan #(.NUM_DIGITS(1), .PRESCALE(PRESC), .ACTIVE_LOW(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  int total = 0;
  int bad   = 0;
  obs_t q4[$];
  obs_t q1[$];
  mstate_t st4, st1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  // One clock of the reference: n digits, al = active-low pins.
  function automatic void step(input int n, input bit al, input logic rst, input logic ld,
                               input logic [15:0] v, input logic [3:0] d,
                               input mstate_t si, output mstate_t so, output obs_t o);
    int         digit;
    bit         wrap;
    logic [6:0] seg;
    logic [3:0] an_hi, mask;
    so    = si;
    o     = '0;
    mask  = 4'((1 << n) - 1);
    if (!rst) begin
      so     = '0;
      o.seg  = al ? 7'h7F : 7'h00;
      o.dp   = al;
      o.an   = al ? mask : 4'h0;
      return;
    end
    so.k  = si.k + 1;
    digit = int'(((so.k - 1) / PRESC) % n);
    wrap  = (so.k % (PRESC * n)) == 0;
    seg   = SEG_REF[si.disp[4*digit +: 4]];
`ifdef LEADING_ZERO_BLANK_EN
    if (digit > 0 && (si.disp >> (4 * digit)) == 16'h0) seg = 7'h00;
`endif
    an_hi = 4'(1 << digit);
    o.seg = al ? ~seg : seg;
    o.dp  = al ? ~si.ddp[digit] : si.ddp[digit];
    o.an  = al ? (~an_hi & mask) : an_hi;
    o.ft  = wrap;
    if (wrap && (ld || si.pend)) begin
      so.disp = ld ? v : si.pval;
      so.ddp  = ld ? d : si.pdp;
      so.pend = 1'b0;
      o.ack   = 1'b1;
    end else if (ld) begin
      so.pval = v;
      so.pdp  = d;
      so.pend = 1'b1;
    end
    o.pend = so.pend;
  endfunction

  // Reference model: pushes the expected outputs for every clock edge.
  initial begin
    obs_t    o;
    mstate_t n4, n1;
    st4 = '0;
    st1 = '0;
    forever begin
      @(posedge clk);
      step(4, 1'b0, rst_n, bus4.load, bus4.value, bus4.dp_in, st4, n4, o);
      st4 = n4;
      q4.push_back(o);
      step(1, 1'b1, rst_n, bus1.load, {12'h000, bus1.value}, {3'b000, bus1.dp_in}, st1, n1, o);
      st1 = n1;
      q1.push_back(o);
    end
  end

  // Monitor: compares DUT outputs on the falling edge against the queue.
  initial begin
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (q4.size() > 0) begin
        e = q4.pop_front();
        a = {bus4.seg, bus4.dp, bus4.an, bus4.frame_tick, bus4.load_ack, bus4.pend};
        check("dut4_outputs", 32'(a), 32'(e));
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        a = {bus1.seg, bus1.dp, 3'b000, bus1.an, bus1.frame_tick, bus1.load_ack, bus1.pend};
        check("dut1_outputs", 32'(a), 32'(e));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load4(input logic [15:0] v, input logic [3:0] d);
    @(negedge clk);
    bus4.load = 1'b1; bus4.value = v; bus4.dp_in = d;
    @(negedge clk);
    bus4.load = 1'b0;
  endtask

  task automatic load1(input logic [3:0] v, input logic d);
    @(negedge clk);
    bus1.load = 1'b1; bus1.value = v; bus1.dp_in = d;
    @(negedge clk);
    bus1.load = 1'b0;
  endtask

  // Assert load so it is sampled on the frame-wrap edge.
  task automatic load4_on_wrap(input logic [15:0] v, input logic [3:0] d);
    int i = 0;
    while (((st4.k + 1) % (PRESC * 4)) != 0 && i < 64) begin
      @(negedge clk);
      i++;
    end
    bus4.load = 1'b1; bus4.value = v; bus4.dp_in = d;
    @(negedge clk);
    bus4.load = 1'b0;
  endtask

  initial begin
    bit seen;
    bus4.load = 1'b0; bus4.value = '0; bus4.dp_in = '0;
    bus1.load = 1'b0; bus1.value = '0; bus1.dp_in = '0;

    // Reset held for three clocks, then one clean frame.
    idle(3);
    rst_n = 1'b1;
    idle(16);

    // Mid-frame load, commit at the wrap.
    idle(2);
    load4(16'h1234, 4'b0000);
    load1(4'h8, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus4.load_ack) seen = 1'b1;
    end
    check("ack_after_1234", 32'(seen), 32'd1);
    idle(16);

    // Last load before the wrap wins, single ack.
    load4_on_wrap(16'h0000, 4'b0000);
    idle(2);
    load4(16'hAAAA, 4'b0101);
    load4(16'hBEEF, 4'b1000);
    idle(20);

    // Load exactly on the wrap: bypass, with and without data already pending.
    load4_on_wrap(16'h5555, 4'b0010);
    idle(4);
    load4(16'h9999, 4'b0000);
    load4_on_wrap(16'h0042, 4'b0001);
    idle(16);
    load4_on_wrap(16'h0000, 4'b0000);
    idle(16);

    // Every nibble through the decoder.
    load4_on_wrap(16'h3210, 4'b0000); idle(15);
    load4_on_wrap(16'h7654, 4'b1111); idle(15);
    load4_on_wrap(16'hBA98, 4'b0000); idle(15);
    load4_on_wrap(16'hFEDC, 4'b0110); idle(15);

    // Reset with data pending discards everything.
    load4(16'h4321, 4'b1111);
    load1(4'hC, 1'b1);
    idle(1);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(20);

    // Random loads on both instances.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      bus4.load  = ($urandom_range(0, 6) == 0);
      bus4.value = 16'($urandom);
      if ($urandom_range(0, 3) == 0) bus4.value = 16'($urandom_range(0, 255));
      bus4.dp_in = 4'($urandom);
      bus1.load  = ($urandom_range(0, 4) == 0);
      bus1.value = 4'($urandom);
      bus1.dp_in = 1'($urandom);
    end
    @(negedge clk);
    bus4.load = 1'b0;
    bus1.load = 1'b0;
    idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got=running exp=finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
